butterfly_pipe: RTL and testbench

- Pipelined, parametrised radix-2 DIT butterfly: out0 = a + b·W, out1 = a − b·W on signed fixed-point complex samples.
- Successor to the combinational butterfly. Adds:
  - parametrised width and fraction
  - 3-stage pipeline with valid/ready backpressure
  - rounding
  - per-transaction inverse (conjugate twiddle) and scale-by-½ modes
  - overflow reporting
- Sits between the FFT stage sample buffer and the twiddle ROM. One butterfly per clock at full throughput.

---
 rtl/fft_pkg.sv | 51 +++++
 rtl/butterfly_pipe_if.sv | 52 +++++
 rtl/cmult_round.sv | 83 ++++++++
 rtl/butterfly_pipe.sv | 111 +++++++++++
 tb/tb_butterfly_pipe.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT datapath constants, types and fixed-point helpers.
// BUTTERFLY_SAT_EN: fit_width clamps out-of-range values instead of wrapping.
package fft_pkg;

  localparam int DATA_W_DEF = 23;
  localparam int FRAC_W_DEF = 15;

  typedef struct packed {
    logic signed [DATA_W_DEF-1:0] real_bits;
    logic signed [DATA_W_DEF-1:0] imaginary_bits;
  } fixed_point;

  function automatic longint ROUND_HALF(input int frac_w);
    return longint'(1) <<< (frac_w - 1);
  endfunction

  function automatic logic out_of_range(
    input longint x,
    input int     w
  );
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    return (x > hi) || (x < lo);
  endfunction

  function automatic longint fit_width(
    input longint x,
    input int     w
  );
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
`ifdef BUTTERFLY_SAT_EN
    if (x > hi)
      return hi;
    else if (x < lo)
      return lo;
    else
      return x;
`else
    // wrap: keep the low w bits, sign-extended
    if (hi < lo)
      return x;
    return (x <<< (64 - w)) >>> (64 - w);
`endif
  endfunction

endpackage

// File: rtl/butterfly_pipe_if.sv
// butterfly_pipe_if: input/output valid-ready bus of the butterfly.
// Ports: in_* (a, b, twiddle, modes), out_* (results, ovf), ovf_clr.
interface butterfly_pipe_if
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a_re;
  logic signed [DATA_W-1:0] in_a_im;
  logic signed [DATA_W-1:0] in_b_re;
  logic signed [DATA_W-1:0] in_b_im;
  logic signed [DATA_W-1:0] in_tw_re;
  logic signed [DATA_W-1:0] in_tw_im;
  logic                     in_inverse;
  logic                     in_scale;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out0_re;
  logic signed [DATA_W-1:0] out0_im;
  logic signed [DATA_W-1:0] out1_re;
  logic signed [DATA_W-1:0] out1_im;
  logic                     out_ovf;
  logic                     ovf_sticky;
  logic                     ovf_clr;

  modport master (
    output in_valid, in_a_re, in_a_im,
    output in_b_re, in_b_im,
    output in_tw_re, in_tw_im,
    output in_inverse, in_scale,
    output out_ready, ovf_clr,
    input  in_ready, out_valid,
    input  out0_re, out0_im,
    input  out1_re, out1_im,
    input  out_ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, in_a_re, in_a_im,
    input  in_b_re, in_b_im,
    input  in_tw_re, in_tw_im,
    input  in_inverse, in_scale,
    input  out_ready, ovf_clr,
    output in_ready, out_valid,
    output out0_re, out0_im,
    output out1_re, out1_im,
    output out_ovf, ovf_sticky
  );

endinterface

// File: rtl/cmult_round.sv
// cmult_round: 2-stage complex multiply b*W (or b*conj(W)), rounded half-up.
// Ports: clk, rst_n, en, in_valid, b/w in, conj; out_valid, p_re/p_im.
module cmult_round
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [DATA_W-1:0] w_re,
  input  logic signed [DATA_W-1:0] w_im,
  input  logic                     conj,
  output logic                     out_valid,
  output logic signed [DATA_W+1:0] p_re,
  output logic signed [DATA_W+1:0] p_im
);

  localparam int PW = 2 * DATA_W + 1;
  localparam logic signed [DATA_W-1:0] MAXV =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MINV =
    {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [PW-1:0] HALF =
    PW'(ROUND_HALF(FRAC_W));

  logic                     v1;
  logic signed [DATA_W-1:0] b1_re, b1_im;
  logic signed [DATA_W-1:0] w1_re, w1_im;
  logic signed [DATA_W-1:0] w_im_c;

  // -MINV does not fit, so conjugation saturates it to MAXV
  always_comb begin
    w_im_c = w_im;
    if (conj)
      w_im_c = (w_im == MINV) ? MAXV : -w_im;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      b1_re <= '0;
      b1_im <= '0;
      w1_re <= '0;
      w1_im <= '0;
    end else if (en) begin
      v1    <= in_valid;
      b1_re <= b_re;
      b1_im <= b_im;
      w1_re <= w_re;
      w1_im <= w_im_c;
    end
  end

  logic signed [2*DATA_W-1:0] m_rr, m_ii, m_ir, m_ri;
  logic signed [PW-1:0]       pr, pi, pr_s, pi_s;

  assign m_rr = b1_re * w1_re;
  assign m_ii = b1_im * w1_im;
  assign m_ir = b1_im * w1_re;
  assign m_ri = b1_re * w1_im;
  assign pr   = PW'(m_rr) - PW'(m_ii);
  assign pi   = PW'(m_ir) + PW'(m_ri);
  assign pr_s = (pr + HALF) >>> FRAC_W;
  assign pi_s = (pi + HALF) >>> FRAC_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p_re      <= '0;
      p_im      <= '0;
    end else if (en) begin
      out_valid <= v1;
      p_re      <= pr_s[DATA_W+1:0];
      p_im      <= pi_s[DATA_W+1:0];
    end
  end

endmodule

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: 3-stage radix-2 DIT butterfly a +/- b*W, valid/ready.
// Ports: clk, rst_n, bus (slave). Option: BUTTERFLY_SAT_EN saturates.
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  butterfly_pipe_if.slave  bus
);

  localparam int SW = DATA_W + 3;

  logic en;
  assign en          = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = en;

  logic                     v2;
  logic signed [DATA_W+1:0] p_re, p_im;

  cmult_round #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_cmult (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (bus.in_valid),
    .b_re      (bus.in_b_re),
    .b_im      (bus.in_b_im),
    .w_re      (bus.in_tw_re),
    .w_im      (bus.in_tw_im),
    .conj      (bus.in_inverse),
    .out_valid (v2),
    .p_re      (p_re),
    .p_im      (p_im)
  );

  logic signed [DATA_W-1:0] a1_re, a1_im, a2_re, a2_im;
  logic                     sc1, sc2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_re <= '0;
      a1_im <= '0;
      a2_re <= '0;
      a2_im <= '0;
      sc1   <= 1'b0;
      sc2   <= 1'b0;
    end else if (en) begin
      a1_re <= bus.in_a_re;
      a1_im <= bus.in_a_im;
      sc1   <= bus.in_scale;
      a2_re <= a1_re;
      a2_im <= a1_im;
      sc2   <= sc1;
    end
  end

  logic signed [SW-1:0]     s [4];
  logic signed [DATA_W-1:0] o [4];
  logic                     ovf_any;
  longint                   r;

  always_comb begin
    s[0]    = SW'(a2_re) + SW'(p_re);
    s[1]    = SW'(a2_im) + SW'(p_im);
    s[2]    = SW'(a2_re) - SW'(p_re);
    s[3]    = SW'(a2_im) - SW'(p_im);
    ovf_any = 1'b0;
    r       = 0;
    for (int i = 0; i < 4; i++) begin
      if (sc2)
        s[i] = (s[i] + SW'(1)) >>> 1;
      ovf_any = ovf_any | out_of_range(longint'(s[i]), DATA_W);
      r       = fit_width(longint'(s[i]), DATA_W);
      o[i]    = r[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_ovf   <= 1'b0;
      bus.out0_re   <= '0;
      bus.out0_im   <= '0;
      bus.out1_re   <= '0;
      bus.out1_im   <= '0;
    end else if (en) begin
      bus.out_valid <= v2;
      bus.out_ovf   <= ovf_any;
      bus.out0_re   <= o[0];
      bus.out0_im   <= o[1];
      bus.out1_re   <= o[2];
      bus.out1_im   <= o[3];
    end
  end

  // a setting transfer takes priority over a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.ovf_sticky <= 1'b0;
    else if (bus.out_valid & bus.out_ready & bus.out_ovf)
      bus.ovf_sticky <= 1'b1;
    else if (bus.ovf_clr)
      bus.ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: vector table, hand sequences and random traffic
// against a scoreboard fed by an arithmetic reference model.
`timescale 1ns/1ps
module tb_butterfly_pipe;

  localparam int DW = 23;
  localparam int FW = 15;
  localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (DW - 1));
  localparam longint HALF = longint'(1) << (FW - 1);
  localparam longint ONE  = longint'(1) << FW;

  typedef struct {
    longint a_re, a_im, b_re, b_im, tw_re, tw_im;
    bit     inv, sc;
    longint o0r, o0i, o1r, o1i;
    bit     ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  butterfly_pipe_if #(.DATA_W(DW)) bus ();

  butterfly_pipe #(
    .DATA_W (DW),
    .FRAC_W (FW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;
  vec_t sbq[$];

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic longint sext(longint x, int w);
    longint m;
    m = x & ((longint'(1) << w) - 1);
    if (m >= (longint'(1) << (w - 1)))
      m = m - (longint'(1) << w);
    return m;
  endfunction

  // floor((x + 1/2 lsb) / 2^FW), i.e. round half toward +inf
  function automatic longint rnd_q(longint x);
    longint n;
    n = x + HALF;
    if (n >= 0)
      return n / ONE;
    return -((-n + ONE - 1) / ONE);
  endfunction

  function automatic longint fit(longint x, inout bit ovf);
    if (x <= MAXV && x >= MINV)
      return x;
    ovf = 1'b1;
`ifdef BUTTERFLY_SAT_EN
    return (x > MAXV) ? MAXV : MINV;
`else
    return sext(x, DW);
`endif
  endfunction

  function automatic longint halve(longint x, bit sc);
    if (!sc)
      return x;
    if (x + 1 >= 0)
      return (x + 1) / 2;
    return -((-(x + 1) + 1) / 2);
  endfunction

  function automatic vec_t model(vec_t v);
    vec_t   r;
    longint wi, pr, pi;
    r     = v;
    r.ovf = 1'b0;
    wi    = v.tw_im;
    if (v.inv)
      wi = (v.tw_im == MINV) ? MAXV : -v.tw_im;
    pr    = sext(rnd_q(v.b_re * v.tw_re - v.b_im * wi), DW + 2);
    pi    = sext(rnd_q(v.b_im * v.tw_re + v.b_re * wi), DW + 2);
    r.o0r = fit(halve(v.a_re + pr, v.sc), r.ovf);
    r.o0i = fit(halve(v.a_im + pi, v.sc), r.ovf);
    r.o1r = fit(halve(v.a_re - pr, v.sc), r.ovf);
    r.o1i = fit(halve(v.a_im - pi, v.sc), r.ovf);
    return r;
  endfunction

  function automatic vec_t mk(
    longint ar, longint ai, longint br, longint bi,
    longint wr, longint wim, bit inv, bit sc,
    longint e0r, longint e0i, longint e1r, longint e1i,
    bit ovf
  );
    vec_t v;
    v.a_re = ar;  v.a_im = ai;
    v.b_re = br;  v.b_im = bi;
    v.tw_re = wr; v.tw_im = wim;
    v.inv = inv;  v.sc = sc;
    v.o0r = e0r;  v.o0i = e0i;
    v.o1r = e1r;  v.o1i = e1i;
    v.ovf = ovf;
    return v;
  endfunction

  function automatic longint rnd_w(int w);
    longint x;
    x = longint'($urandom) & ((longint'(1) << w) - 1);
    return sext(x, w);
  endfunction

  function automatic longint rnd_s();
    case ($urandom_range(0, 7))
      0: return MAXV;
      1: return MINV;
      default: return rnd_w(DW);
    endcase
  endfunction

  function automatic vec_t rnd_vec(bit unit_tw);
    vec_t v;
    v = mk(rnd_s(), rnd_s(), rnd_s(), rnd_s(), 0, 0,
           1'($urandom), 1'($urandom), 0, 0, 0, 0, 1'b0);
    if (unit_tw) begin
      v.tw_re = longint'($urandom_range(0, 65536)) - ONE;
      v.tw_im = longint'($urandom_range(0, 65536)) - ONE;
    end else begin
      v.tw_re = rnd_s();
      v.tw_im = rnd_s();
    end
    return v;
  endfunction

  // monitor: scoreboard on output transfers, hold check while stalled
  logic            held;
  logic [4*DW:0]   snap;
  logic [4*DW:0]   cur;
  vec_t            mv;
  vec_t            ev;

  always @(negedge clk) begin
    cur = {bus.out0_re, bus.out0_im, bus.out1_re,
           bus.out1_im, bus.out_ovf};
    if (!rst_n) begin
      held = 1'b0;
      sbq.delete();
    end else begin
      if (held) begin
        total++;
        if ({bus.out_valid, cur} !== {1'b1, snap}) begin
          bad++;
          $display("FAIL hold: got v=%0b %h want v=1 %h",
                   bus.out_valid, cur, snap);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra: got output %h want none", cur);
        end else begin
          ev = sbq.pop_front();
          chk("sb_o0r", bus.out0_re, ev.o0r);
          chk("sb_o0i", bus.out0_im, ev.o0i);
          chk("sb_o1r", bus.out1_re, ev.o1r);
          chk("sb_o1i", bus.out1_im, ev.o1i);
          chk("sb_ovf", bus.out_ovf, ev.ovf);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        mv = mk(bus.in_a_re, bus.in_a_im, bus.in_b_re,
                bus.in_b_im, bus.in_tw_re, bus.in_tw_im,
                bus.in_inverse, bus.in_scale,
                0, 0, 0, 0, 1'b0);
        sbq.push_back(model(mv));
      end
      held = bus.out_valid && !bus.out_ready;
      snap = cur;
    end
  end

  task automatic drive(vec_t v);
    bus.in_a_re    = DW'(v.a_re);
    bus.in_a_im    = DW'(v.a_im);
    bus.in_b_re    = DW'(v.b_re);
    bus.in_b_im    = DW'(v.b_im);
    bus.in_tw_re   = DW'(v.tw_re);
    bus.in_tw_im   = DW'(v.tw_im);
    bus.in_inverse = v.inv;
    bus.in_scale   = v.sc;
  endtask

  // called just after a rising edge; returns just after the transfer edge
  task automatic send(vec_t v);
    int   k;
    logic acc;
    k = 0;
    drive(v);
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      k++;
    end while (!acc && k < 100);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end
  endtask

  task automatic run_vec(vec_t v, string nm);
    int n;
    send(v);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_lat"}, n, 3);
    chk({nm, "_o0r"}, bus.out0_re, v.o0r);
    chk({nm, "_o0i"}, bus.out0_im, v.o0i);
    chk({nm, "_o1r"}, bus.out1_re, v.o1r);
    chk({nm, "_o1i"}, bus.out1_im, v.o1i);
    chk({nm, "_ovf"}, bus.out_ovf, v.ovf);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!bus.out_valid && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("wait_valid", bus.out_valid, 1);
  endtask

  task automatic drain(string nm);
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(nm, sbq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  vec_t   tbl[10];
  vec_t   bp[8];
  vec_t   ovf_v;
  longint wrap_ovf;
  int     n0;
  bit     a_done;

  initial begin
`ifdef BUTTERFLY_SAT_EN
    wrap_ovf = MAXV;
`else
    wrap_ovf = -2;
`endif
    tbl[0] = mk(1000, 0, 500, 0, ONE, 0, 0, 0,
                1500, 0, 500, 0, 0);
    tbl[1] = mk(0, 0, ONE, 0, 0, -ONE, 0, 0,
                0, -ONE, 0, ONE, 0);
    tbl[2] = mk(0, 0, ONE, 0, 0, -ONE, 1, 0,
                0, ONE, 0, -ONE, 0);
    tbl[3] = mk(0, 0, 1, 0, HALF, 0, 0, 0,
                1, 0, -1, 0, 0);
    tbl[4] = mk(3, 0, 0, 0, ONE, 0, 0, 1,
                2, 0, 2, 0, 0);
    tbl[5] = mk(-3, 0, 0, 0, ONE, 0, 0, 1,
                -1, 0, -1, 0, 0);
    tbl[6] = mk(10, 20, 100, 50, -ONE, 0, 0, 0,
                -90, -30, 110, 70, 0);
    tbl[7] = mk(5, 5, -1, 0, HALF, 0, 0, 0,
                5, 5, 5, 5, 0);
    tbl[8] = mk(0, 0, 1, 0, 0, MINV, 1, 0,
                0, 128, 0, -128, 0);
    tbl[9] = mk(MAXV, 0, MAXV, 0, ONE, 0, 0, 0,
                wrap_ovf, 0, 0, 0, 1);
    ovf_v  = tbl[9];

    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.ovf_clr    = 1'b0;
    drive(tbl[0]);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_ovf", bus.out_ovf, 0);
    chk("rst_sticky", bus.ovf_sticky, 0);
    chk("rst_out0_re", bus.out0_re, 0);
    chk("rst_out1_im", bus.out1_im, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 9; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_sticky", i), bus.ovf_sticky, 0);
    end
    run_vec(tbl[9], "vec_ovf");
    chk("sticky_set", bus.ovf_sticky, 1);

    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.ovf_clr = 1'b0;
    chk("sticky_clr", bus.ovf_sticky, 0);

    bus.out_ready = 1'b0;
    send(ovf_v);
    bus.in_valid = 1'b0;
    wait_valid();
    bus.ovf_clr   = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.ovf_clr = 1'b0;
    chk("sticky_set_wins", bus.ovf_sticky, 1);
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.ovf_clr = 1'b0;

    for (int i = 0; i < 8; i++)
      bp[i] = rnd_vec(1'b1);
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(bp[i]);
        bus.in_valid = 1'b0;
      end
      begin
        bus.out_ready = 1'b1;
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", bus.in_ready, 0);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_count", n_out - n0, 8);

    bus.out_ready = 1'b0;
    send(tbl[0]);
    send(tbl[6]);
    bus.in_valid = 1'b0;
    wait_valid();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", bus.out_valid, 0);
    chk("rst_async_ovf", bus.out_ovf, 0);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    n0            = n_out;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("rst_no_ghost", n_out - n0, 0);
    run_vec(tbl[6], "post_rst");

    n0     = n_out;
    a_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          bus.in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(rnd_vec(i[0]));
        end
        bus.in_valid = 1'b0;
        a_done = 1'b1;
      end
      begin
        while (!a_done) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain("rand_drain");
    chk("rand_count", n_out - n0, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
